division_seq: RTL

Parametrised sequential unsigned divider, the multi-cycle successor to the team's 2-bit combinational divider in the calculator datapath. It accepts a WIDTH-bit dividend and divisor on a start strobe and computes quotient and remainder by restoring division, one quotient bit per clock. Results are announced with a one-cycle done pulse. Divide-by-zero is flagged explicitly instead of producing undefined output.

---
 rtl/division_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/division_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, a one-cycle
// done pulse with each result, and an explicit divide-by-zero flag.
module division_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shifts out at the MSB, quotient bits enter at the LSB
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             dz_q, dz_d;

    logic             accept;
    logic             last_step;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             qbit;

    assign accept    = start && (state_q != RUN);
    assign last_step = (state_q == RUN) && (cnt_q == CW'(1));

    // The partial remainder is always below the divisor, so the shift into
    // WIDTH+1 bits is lossless and the trial difference fits WIDTH+1 signed bits.
    assign shifted = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign qbit    = ~trial[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = (b == '0) ? DONE : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_comb begin
        dvd_d = dvd_q;
        dvs_d = dvs_q;
        rem_d = rem_q;
        cnt_d = cnt_q;
        quo_d = quo_q;
        res_d = res_q;
        dz_d  = dz_q;
        if (accept) begin
            dvd_d = a;
            dvs_d = b;
            rem_d = '0;
            cnt_d = CW'(WIDTH);
            if (b == '0) begin
                quo_d = '1;
                res_d = a;
                dz_d  = 1'b1;
            end
        end else if (state_q == RUN) begin
            rem_d = qbit ? trial : shifted;
            dvd_d = {dvd_q[WIDTH-2:0], qbit};
            cnt_d = cnt_q - CW'(1);
            if (last_step) begin
                quo_d = dvd_d;
                res_d = rem_d[WIDTH-1:0];
                dz_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            quo_q <= '0;
            res_q <= '0;
            dz_q  <= 1'b0;
        end else begin
            dvd_q <= dvd_d;
            dvs_q <= dvs_d;
            rem_q <= rem_d;
            cnt_q <= cnt_d;
            quo_q <= quo_d;
            res_q <= res_d;
            dz_q  <= dz_d;
        end
    end

    assign q        = quo_q;
    assign r        = res_q;
    assign div_zero = dz_q;

endmodule
